// File: rtl/wb_write_queue.sv
// wb_write_queue: writeback queue feeding the eight 8-bit register cells
// (B,C,D,E,H,L,F,A). It buffers byte and pair write requests, splits each
// pair into two byte writes with the high byte first, and issues one register
// write per cycle on a shared data bus with one-hot write enables.
// Optional feature: define WB_BYPASS_EN to build the pending-write lookup
// (lk_idx / lk_hit / lk_data).
module wb_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_pair,
    input  logic [2:0]  req_idx,
    input  logic [15:0] req_data,
    output logic [7:0]  reg_wr,
    output logic [7:0]  reg_we,
    output logic        wb_idle
`ifdef WB_BYPASS_EN
    ,
    input  logic [2:0]  lk_idx,
    output logic        lk_hit,
    output logic [7:0]  lk_data
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, LOW} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_nxt;
    logic            push, pop, issue, more;
    logic [2:0]      tgt;
    logic [7:0]      val;
    logic [7:0]      we_nxt, wr_nxt;

    logic            mem_pair [DEPTH];
    logic [2:0]      mem_idx  [DEPTH];
    logic [15:0]     mem_data [DEPTH];

    logic            head_pair;
    logic [2:0]      head_idx;
    logic [15:0]     head_data;

    // Pair high byte: BC->B, DE->D, HL->H, AF->A.
    function automatic logic [2:0] hi_idx(input logic [1:0] p);
        return (p == 2'd3) ? 3'd7 : {p, 1'b0};
    endfunction

    // Pair low byte: BC->C, DE->E, HL->L, AF->F.
    function automatic logic [2:0] lo_idx(input logic [1:0] p);
        return (p == 2'd3) ? 3'd6 : {p, 1'b1};
    endfunction

    // The low nibble of the flags register always reads as zero.
    function automatic logic [7:0] f_mask(input logic [2:0] t, input logic [7:0] v);
        return (t == 3'd6) ? {v[7:4], 4'b0000} : v;
    endfunction

    assign push      = req_valid && req_ready;
    assign more      = (count > CW'(1)) || push;
    assign head_pair = mem_pair[rd_ptr];
    assign head_idx  = mem_idx[rd_ptr];
    assign head_data = mem_data[rd_ptr];
    assign wb_idle   = (count == '0) && (state == IDLE);

    // FIFO storage: written on accept, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pair[wr_ptr] <= req_pair;
            mem_idx[wr_ptr]  <= req_idx;
            mem_data[wr_ptr] <= req_data;
        end
    end

    // Occupancy update; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Drain FSM: choose the byte to issue next edge and whether the head pops.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        issue     = 1'b0;
        tgt       = '0;
        val       = '0;
        case (state)
            IDLE: begin
                if (push) state_nxt = ISSUE;
            end
            ISSUE: begin
                issue = 1'b1;
                if (head_pair) begin
                    tgt       = hi_idx(head_idx[1:0]);
                    val       = head_data[15:8];
                    state_nxt = LOW;
                end else begin
                    tgt       = head_idx;
                    val       = head_data[7:0];
                    pop       = 1'b1;
                    state_nxt = more ? ISSUE : IDLE;
                end
            end
            LOW: begin
                issue     = 1'b1;
                tgt       = lo_idx(head_idx[1:0]);
                val       = head_data[7:0];
                pop       = 1'b1;
                state_nxt = more ? ISSUE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        we_nxt = issue ? (8'(1) << tgt) : '0;
        wr_nxt = issue ? f_mask(tgt, val) : '0;
    end

    // State, pointers, registered ready and registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            req_ready <= 1'b1;
            reg_we    <= '0;
            reg_wr    <= '0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            req_ready <= (count_nxt < CW'(DEPTH));
            reg_we    <= we_nxt;
            reg_wr    <= wr_nxt;
        end
    end

`ifdef WB_BYPASS_EN
    logic [AW-1:0] slot;
    logic [7:0]    lk_val;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        lk_hit = 1'b0;
        lk_val = '0;
        slot   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + AW'(i);
            if (CW'(i) < count) begin
                if (!mem_pair[slot]) begin
                    if (mem_idx[slot] == lk_idx) begin
                        lk_hit = 1'b1;
                        lk_val = mem_data[slot][7:0];
                    end
                end else begin
                    if (hi_idx(mem_idx[slot][1:0]) == lk_idx) begin
                        lk_hit = 1'b1;
                        lk_val = mem_data[slot][15:8];
                    end
                    if (lo_idx(mem_idx[slot][1:0]) == lk_idx) begin
                        lk_hit = 1'b1;
                        lk_val = mem_data[slot][7:0];
                    end
                end
            end
        end
        lk_data = lk_hit ? f_mask(lk_idx, lk_val) : '0;
    end
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed self-checking bench for wb_write_queue (DEPTH = 4).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_wb_write_queue;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_pair;
    logic [2:0]  req_idx;
    logic [15:0] req_data;
    logic [7:0]  reg_wr;
    logic [7:0]  reg_we;
    logic        wb_idle;
`ifdef WB_BYPASS_EN
    logic [2:0]  lk_idx;
    logic        lk_hit;
    logic [7:0]  lk_data;
`endif

    int checks = 0;
    int fails  = 0;

    // Expected write stream for the full/backpressure scenario:
    // pair k uses idx k%4 and data {8'h10+k, 8'h20+k}.
    localparam logic [7:0] FULL_WE [14] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h80,
        8'h40, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    localparam logic [7:0] FULL_WR [14] = '{
        8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13,
        8'h20, 8'h14, 8'h24, 8'h15, 8'h25, 8'h16, 8'h26};

    wb_write_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pair  (req_pair),
        .req_idx   (req_idx),
        .req_data  (req_data),
        .reg_wr    (reg_wr),
        .reg_we    (reg_we),
        .wb_idle   (wb_idle)
`ifdef WB_BYPASS_EN
        ,
        .lk_idx    (lk_idx),
        .lk_hit    (lk_hit),
        .lk_data   (lk_data)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic p, input logic [2:0] i, input logic [15:0] d);
        req_valid = v;
        req_pair  = p;
        req_idx   = i;
        req_data  = d;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (wb_idle !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (wb_idle !== 1'b1) begin
            fails++;
            $display("FAIL %s: drain timeout, wb_idle=%b required 1", name, wb_idle);
        end
    endtask

    task automatic test_reset;
        // power-on reset
        #2 rst = 1'b1;
        #1;
        checks++;
        if (reg_we !== 8'h00 || reg_wr !== 8'h00 || req_ready !== 1'b1 || wb_idle !== 1'b1) begin
            fails++;
            $display("FAIL reset_por: we=%h wr=%h ready=%b idle=%b required 00 00 1 1",
                     reg_we, reg_wr, req_ready, wb_idle);
        end
        step();
        rst = 1'b0;
        step();
        // reset mid-pair: high byte issued, low byte must never appear
        drive(1'b1, 1'b1, 3'd1, 16'hA1B2);
        step();
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
        step();
        checks++;
        if (reg_we !== 8'h04 || reg_wr !== 8'hA1) begin
            fails++;
            $display("FAIL reset_pre_hi: we=%h wr=%h required 04 A1", reg_we, reg_wr);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (reg_we !== 8'h00 || reg_wr !== 8'h00 || req_ready !== 1'b1 || wb_idle !== 1'b1) begin
            fails++;
            $display("FAIL reset_async: we=%h wr=%h ready=%b idle=%b required 00 00 1 1",
                     reg_we, reg_wr, req_ready, wb_idle);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (reg_we !== 8'h00 || wb_idle !== 1'b1) begin
                fails++;
                $display("FAIL reset_discard: we=%h idle=%b required 00 1", reg_we, wb_idle);
            end
        end
    endtask

    task automatic test_byte;
        drive(1'b1, 1'b0, 3'd7, 16'h0042);
        step();
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
        checks++;
        if (reg_we !== 8'h00 || wb_idle !== 1'b0) begin
            fails++;
            $display("FAIL byte_cycleN: we=%h idle=%b required 00 0", reg_we, wb_idle);
        end
        step();
        checks++;
        if (reg_we !== 8'h80 || reg_wr !== 8'h42) begin
            fails++;
            $display("FAIL byte_issue: we=%h wr=%h required 80 42", reg_we, reg_wr);
        end
        step();
        checks++;
        if (reg_we !== 8'h00 || wb_idle !== 1'b1) begin
            fails++;
            $display("FAIL byte_done: we=%h idle=%b required 00 1", reg_we, wb_idle);
        end
    endtask

    task automatic test_pair_order;
        drive(1'b1, 1'b1, 3'd2, 16'hBEEF);
        step();
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
        step();
        checks++;
        if (reg_we !== 8'h10 || reg_wr !== 8'hBE) begin
            fails++;
            $display("FAIL pair_hi: we=%h wr=%h required 10 BE", reg_we, reg_wr);
        end
        step();
        checks++;
        if (reg_we !== 8'h20 || reg_wr !== 8'hEF) begin
            fails++;
            $display("FAIL pair_lo: we=%h wr=%h required 20 EF", reg_we, reg_wr);
        end
        step();
        checks++;
        if (reg_we !== 8'h00 || wb_idle !== 1'b1) begin
            fails++;
            $display("FAIL pair_done: we=%h idle=%b required 00 1", reg_we, wb_idle);
        end
    endtask

    task automatic test_af_fmask;
        drive(1'b1, 1'b1, 3'd3, 16'h12FF);
        step();
        drive(1'b1, 1'b0, 3'd6, 16'h55AB);
        step();
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
        checks++;
        if (reg_we !== 8'h80 || reg_wr !== 8'h12) begin
            fails++;
            $display("FAIL af_hi: we=%h wr=%h required 80 12", reg_we, reg_wr);
        end
        step();
        checks++;
        if (reg_we !== 8'h40 || reg_wr !== 8'hF0) begin
            fails++;
            $display("FAIL af_lo_mask: we=%h wr=%h required 40 F0", reg_we, reg_wr);
        end
        step();
        checks++;
        if (reg_we !== 8'h40 || reg_wr !== 8'hA0) begin
            fails++;
            $display("FAIL f_byte_mask: we=%h wr=%h required 40 A0", reg_we, reg_wr);
        end
        step();
        checks++;
        if (reg_we !== 8'h00 || wb_idle !== 1'b1) begin
            fails++;
            $display("FAIL af_done: we=%h idle=%b required 00 1", reg_we, wb_idle);
        end
    endtask

    task automatic test_back_to_back;
        int k;
        int cyc;
        int stalls;
        logic rdy;
        k = 0;
        cyc = 0;
        stalls = 0;
        // Six pairs fill the queue (drain is 1 entry per 2 cycles), the seventh
        // waits exactly one cycle for the first pop to free a slot.
        fork
            begin
                while (k < 7 && cyc < 40) begin
                    drive(1'b1, 1'b1, 3'(k % 4), {8'(8'h10 + k), 8'(8'h20 + k)});
                    rdy = req_ready;
                    step();
                    if (rdy) k++;
                    else stalls++;
                    cyc++;
                end
                drive(1'b0, 1'b0, 3'd0, 16'h0000);
            end
            begin
                int n;
                n = 0;
                @(posedge clk); #2;
                while (reg_we === 8'h00 && n < 10) begin
                    @(posedge clk); #2;
                    n++;
                end
                for (int j = 0; j < 14; j++) begin
                    checks++;
                    if (reg_we !== FULL_WE[j] || reg_wr !== FULL_WR[j]) begin
                        fails++;
                        $display("FAIL b2b_stream[%0d]: we=%h wr=%h required %h %h",
                                 j, reg_we, reg_wr, FULL_WE[j], FULL_WR[j]);
                    end
                    @(posedge clk); #2;
                end
                checks++;
                if (reg_we !== 8'h00) begin
                    fails++;
                    $display("FAIL b2b_tail: we=%h required 00", reg_we);
                end
            end
        join
        checks++;
        if (k !== 7 || stalls !== 1) begin
            fails++;
            $display("FAIL b2b_backpressure: accepted=%0d stalls=%0d required 7 1", k, stalls);
        end
        wait_idle("b2b_idle");
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass;
        lk_idx = 3'd1;
        drive(1'b1, 1'b0, 3'd1, 16'h0011);
        step();
        drive(1'b1, 1'b1, 3'd0, 16'h2233);
        step();
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
        checks++;
        if (lk_hit !== 1'b1 || lk_data !== 8'h33) begin
            fails++;
            $display("FAIL bypass_c: hit=%b data=%h required 1 33", lk_hit, lk_data);
        end
        lk_idx = 3'd0;
        #1;
        checks++;
        if (lk_hit !== 1'b1 || lk_data !== 8'h22) begin
            fails++;
            $display("FAIL bypass_b: hit=%b data=%h required 1 22", lk_hit, lk_data);
        end
        lk_idx = 3'd1;
        wait_idle("bypass_idle");
        checks++;
        if (lk_hit !== 1'b0 || lk_data !== 8'h00) begin
            fails++;
            $display("FAIL bypass_empty: hit=%b data=%h required 0 00", lk_hit, lk_data);
        end
    endtask
`endif

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
`ifdef WB_BYPASS_EN
        lk_idx = 3'd0;
`endif
        test_reset();
        test_byte();
        test_pair_order();
        test_af_fmask();
        test_back_to_back();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
